// File: rtl/lfsr_encrypter_pkg.sv
// Shared types, memory-map constants and helpers for the LFSR encryption engine.
package enc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_C_PRE  = 3'd1,
        S_C_PTRN = 3'd2,
        S_C_INIT = 3'd3,
        S_C_CAP  = 3'd4,
        S_E_RD   = 3'd5,
        S_E_WR   = 3'd6,
        S_DONE   = 3'd7
    } state_e;

    localparam int         MSG_LEN   = 64;
    localparam logic [7:0] ADDR_PRE  = 8'd61;
    localparam logic [7:0] ADDR_PTRN = 8'd62;
    localparam logic [7:0] ADDR_SEED = 8'd63;
    localparam logic [7:0] OUT_BASE  = 8'd64;
    localparam logic [4:0] PRE_MIN   = 5'd10;
    localparam logic [4:0] PRE_MAX   = 5'd26;

    // Bit that makes the full byte {p, d} carry an even number of ones.
    function automatic logic parity7(input logic [6:0] d);
        return ^d;
    endfunction

    function automatic logic [4:0] clamp_pre(input logic [4:0] raw);
        if (raw < PRE_MIN) begin
            return PRE_MIN;
        end
        if (raw > PRE_MAX) begin
            return PRE_MAX;
        end
        return raw;
    endfunction

endpackage

// File: rtl/lfsr_encrypter_if.sv
// Launch handshake plus data-memory port shared between the encrypter and the bench/core.
//
// Handshake: the engine arms while req is sampled high in IDLE, starts on the first
// cycle req is sampled low while armed, raises ack at completion and holds it until
// req is sampled high again. Memory: mem_rd_en/mem_addr are registered by the master,
// the slave returns mem_rdata for that address while the strobe is up and the master
// samples it at the closing rising edge; mem_wr_en commits mem_wdata at the rising
// edge. At most one strobe is high in any cycle.
interface lfsr_encrypter_if;

    logic       req;
    logic       ack;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;

    modport master (
        input  req,
        input  mem_rdata,
        output ack,
        output mem_addr,
        output mem_rd_en,
        output mem_wr_en,
        output mem_wdata
    );

    modport slave (
        output req,
        output mem_rdata,
        input  ack,
        input  mem_addr,
        input  mem_rd_en,
        input  mem_wr_en,
        input  mem_wdata
    );

endinterface

// File: rtl/lfsr_encrypter_lfsr7.sv
// 7-bit Fibonacci-style LFSR with a runtime tap pattern; load wins over step.
module lfsr7 (
    input  logic       clk,
    input  logic       init_n,
    input  logic       load,
    input  logic [6:0] seed,
    input  logic       step,
    input  logic [6:0] ptrn,
    output logic [6:0] state
);

    logic [6:0] r_state;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state <= 7'h00;
        end else if (load) begin
            r_state <= seed;
        end else if (step) begin
            r_state <= {r_state[5:0], ^(r_state & ptrn)};
        end
    end

    assign state = r_state;

endmodule

// File: rtl/lfsr_encrypter.sv
// Encryption engine: reads config and message from data memory and writes a 64-byte
// LFSR-whitened, even-parity stream to DM[64:127]. One memory access per cycle.
module lfsr_encrypter
    import enc_pkg::*;
(
    input  logic             clk,
    input  logic             init_n,
    lfsr_encrypter_if.master bus,
    output state_e           o_dbg_state
);

    state_e     r_state;
    logic       r_armed;
    logic [4:0] r_pre;
    logic [6:0] r_ptrn;
    logic [5:0] r_cnt;
    logic       r_ack;
    logic       r_rd_en;
    logic       r_wr_en;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;

    logic [6:0] w_lfsr;
    logic [6:0] w_seed;
    logic       w_load;
    logic       w_step;
    logic       w_in_msg;
    logic [6:0] w_plain;
    logic [6:0] w_enc;
    logic       w_unused;

    // Plain bit 7 never reaches the output stream.
    assign w_unused = bus.mem_rdata[7];

    assign w_seed   = (bus.mem_rdata[6:0] == 7'h00) ? 7'h01 : bus.mem_rdata[6:0];
    assign w_load   = (r_state == S_C_CAP);
    assign w_step   = (r_state == S_E_WR);
    assign w_in_msg = (r_cnt >= {1'b0, r_pre});
    assign w_plain  = w_in_msg ? bus.mem_rdata[6:0] : 7'h20;
    assign w_enc    = w_plain ^ w_lfsr;

    lfsr7 u_lfsr (
        .clk   (clk),
        .init_n(init_n),
        .load  (w_load),
        .seed  (w_seed),
        .step  (w_step),
        .ptrn  (r_ptrn),
        .state (w_lfsr)
    );

    // Each state registers the strobes for the next cycle; read data returned for a
    // strobe is consumed in the state that follows the one that issued it.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_pre   <= 5'd0;
            r_ptrn  <= 7'd0;
            r_cnt   <= 6'd0;
            r_ack   <= 1'b0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_addr  <= 8'd0;
            r_wdata <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= S_C_PRE;
                    end
                end
                S_C_PRE: begin
                    r_rd_en <= 1'b1;
                    r_addr  <= ADDR_PRE;
                    r_state <= S_C_PTRN;
                end
                S_C_PTRN: begin
                    r_pre   <= clamp_pre(bus.mem_rdata[4:0]);
                    r_addr  <= ADDR_PTRN;
                    r_state <= S_C_INIT;
                end
                S_C_INIT: begin
                    r_ptrn  <= bus.mem_rdata[6:0];
                    r_addr  <= ADDR_SEED;
                    r_state <= S_C_CAP;
                end
                S_C_CAP: begin
                    r_rd_en <= 1'b0;
                    r_cnt   <= 6'd0;
                    r_state <= S_E_RD;
                end
                S_E_RD: begin
                    r_wr_en <= 1'b0;
                    r_rd_en <= w_in_msg;
                    r_addr  <= {2'b00, r_cnt} - {3'b000, r_pre};
                    r_state <= S_E_WR;
                end
                S_E_WR: begin
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b1;
                    r_addr  <= OUT_BASE + {2'b00, r_cnt};
                    r_wdata <= {parity7(w_enc), w_enc};
                    r_cnt   <= r_cnt + 6'd1;
                    if (r_cnt == 6'd63) begin
                        r_ack   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_E_RD;
                    end
                end
                S_DONE: begin
                    r_wr_en <= 1'b0;
                    if (bus.req) begin
                        r_ack   <= 1'b0;
                        r_armed <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack       = r_ack;
    assign bus.mem_rd_en = r_rd_en;
    assign bus.mem_wr_en = r_wr_en;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_lfsr_encrypter.sv
// Self-checking bench for lfsr_encrypter: memory model, access scoreboard and scenario tasks.
module tb_lfsr_encrypter;
    import enc_pkg::*;

    logic   clk = 1'b0;
    logic   init_n = 1'b0;
    state_e dbg_state;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;

    lfsr_encrypter_if bus ();

    lfsr_encrypter dut (
        .clk        (clk),
        .init_n     (init_n),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read of the registered address, writes at the edge.
    logic [7:0] mem [0:255];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
        else if (ld_en)    mem[ld_addr] <= ld_data;
    end

    // Scoreboard entries: {is_write, addr, data(0 for reads)}.
    logic [16:0] exp_q[$];
    logic [16:0] mon_obs;
    logic [16:0] mon_exp;
    logic [7:0]  msg [0:60];
    logic [7:0]  model_out [0:63];
    logic [7:0]  ref_out [0:63];

    always @(negedge clk) begin
        if (init_n && (bus.mem_rd_en || bus.mem_wr_en)) begin
            checks++;
            mon_obs = {bus.mem_wr_en, bus.mem_addr, bus.mem_wr_en ? bus.mem_wdata : 8'h00};
            if (bus.mem_rd_en && bus.mem_wr_en) begin
                errors++;
                $display("FAIL strobe_overlap: got rd=1 wr=1 at cycle %0d, expected one strobe", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_access: got %h at cycle %0d, expected no access", mon_obs, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_obs !== mon_exp) begin
                    errors++;
                    $display("FAIL mem_access: got %h expected %h at cycle %0d", mon_obs, mon_exp, cyc);
                end
            end
        end
    end

    task automatic set_random_msg();
        for (int i = 0; i < 61; i++) msg[i] = 8'($urandom_range(32, 126));
        msg[0] = 8'h66;
    endtask

    task automatic set_text_msg();
        string txt;
        txt = "    four score and seven years ago...";
        for (int i = 0; i < 61; i++) msg[i] = (i < txt.len()) ? txt[i] : 8'h20;
    endtask

    // Message, config bytes, and an odd-parity marker (never a legal output) in DM[64:127].
    task automatic load_dm(input logic [7:0] pre_b, input logic [7:0] ptrn_b, input logic [7:0] seed_b);
        for (int a = 0; a < 128; a++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 8'(a);
            if (a < 61)       ld_data = msg[a];
            else if (a == 61) ld_data = pre_b;
            else if (a == 62) ld_data = ptrn_b;
            else if (a == 63) ld_data = seed_b;
            else              ld_data = 8'h01;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic push_model(input logic [7:0] pre_b, input logic [7:0] ptrn_b, input logic [7:0] seed_b);
        int pre;
        logic [6:0] s;
        logic [6:0] p;
        logic [6:0] e;
        logic [7:0] plain;
        pre = int'(pre_b[4:0]);
        if (pre < 10) pre = 10;
        if (pre > 26) pre = 26;
        p = ptrn_b[6:0];
        s = seed_b[6:0];
        if (s == 7'h00) s = 7'h01;
        exp_q.push_back({1'b0, 8'd61, 8'h00});
        exp_q.push_back({1'b0, 8'd62, 8'h00});
        exp_q.push_back({1'b0, 8'd63, 8'h00});
        for (int i = 0; i < 64; i++) begin
            if (i >= pre) begin
                plain = msg[i - pre];
                exp_q.push_back({1'b0, 8'(i - pre), 8'h00});
            end else begin
                plain = 8'h20;
            end
            e = plain[6:0] ^ s;
            model_out[i] = {^e, e};
            exp_q.push_back({1'b1, 8'(64 + i), model_out[i]});
            s = {s[5:0], ^(s & p)};
        end
    endtask

    // Launch with req already high; lat = cycles from launch cycle L to ack, -1 on timeout.
    task automatic run(output int lat);
        int c0;
        @(negedge clk);
        c0 = cyc;
        bus.req = 1'b0;
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.ack) begin
                lat = cyc - c0 - 1;
                break;
            end
        end
        bus.req = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req = 1'b0;
        init_n  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mem_rd_en, bus.mem_wr_en, bus.ack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 000", {bus.mem_rd_en, bus.mem_wr_en, bus.ack});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bus: got %h expected 0000", {bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if (dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
        end
        init_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL idle_without_arm: got %0d expected %0d", dbg_state, S_IDLE);
        end
    endtask

    task automatic test_req_hold();
        bus.req = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL req_hold: got ack=%b state=%0d expected ack=0 state=%0d", bus.ack, dbg_state, S_IDLE);
        end
    endtask

    task automatic test_basic();
        int lat;
        set_random_msg();
        load_dm(8'd10, 8'h60, 8'h01);
        push_model(8'd10, 8'h60, 8'h01);
        run(lat);
        checks++;
        if (lat != 132) begin errors++; $display("FAIL basic_latency: got %0d expected 132", lat); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_leftover: got %0d expected 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (mem[64] !== 8'h21) begin errors++; $display("FAIL basic_dm64: got %h expected 21", mem[64]); end
        checks++;
        if (mem[65] !== 8'h22) begin errors++; $display("FAIL basic_dm65: got %h expected 22", mem[65]); end
        checks++;
        if (mem[74] !== 8'h7E) begin errors++; $display("FAIL basic_dm74: got %h expected 7e", mem[74]); end
        for (int i = 0; i < 64; i++) ref_out[i] = model_out[i];
    endtask

    task automatic test_same_as_ref(input logic [7:0] pre_b, input logic [7:0] seed_b);
        int lat;
        load_dm(pre_b, 8'h60, seed_b);
        push_model(pre_b, 8'h60, seed_b);
        run(lat);
        checks++;
        if (lat != 132) begin errors++; $display("FAIL ref_latency: got %0d expected 132", lat); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (mem[64 + i] !== ref_out[i]) begin
                errors++;
                $display("FAIL ref_byte[%0d] pre=%h seed=%h: got %h expected %h", i, pre_b, seed_b, mem[64 + i], ref_out[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_pre_max();
        int lat;
        load_dm(8'h1F, 8'h60, 8'h01);
        push_model(8'h1F, 8'h60, 8'h01);
        run(lat);
        checks++;
        if (lat != 132) begin errors++; $display("FAIL premax_latency: got %0d expected 132", lat); end
        checks++;
        if (mem[90] !== model_out[26]) begin errors++; $display("FAIL premax_dm90: got %h expected %h", mem[90], model_out[26]); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL premax_leftover: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_patterns();
        logic [7:0] pats [0:8];
        logic [7:0] seed_b;
        logic [7:0] pre_b;
        int lat;
        pats = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};
        set_text_msg();
        for (int p = 0; p < 9; p++) begin
            seed_b = 8'($urandom_range(0, 255));
            pre_b  = 8'($urandom_range(0, 255));
            load_dm(pre_b, pats[p], seed_b);
            push_model(pre_b, pats[p], seed_b);
            run(lat);
            checks++;
            if (lat != 132) begin errors++; $display("FAIL pat_latency ptrn=%h: got %0d expected 132", pats[p], lat); end
            checks++;
            if (exp_q.size() != 0) begin errors++; $display("FAIL pat_leftover ptrn=%h: got %0d expected 0", pats[p], exp_q.size()); exp_q.delete(); end
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (mem[64 + i] !== model_out[i] || (^mem[64 + i]) !== 1'b0) begin
                    errors++;
                    $display("FAIL pat_byte[%0d] ptrn=%h seed=%h: got %h expected %h (even parity)", i, pats[p], seed_b, mem[64 + i], model_out[i]);
                end
            end
        end
    endtask

    task automatic test_abort();
        int c0;
        int lat;
        set_random_msg();
        load_dm(8'd12, 8'h48, 8'h35);
        push_model(8'd12, 8'h48, 8'h35);
        @(negedge clk);
        c0 = cyc;
        bus.req = 1'b0;
        for (int k = 0; k < 100 && cyc < c0 + 41; k++) @(negedge clk);
        #2;
        init_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_rd_en, bus.mem_wr_en, bus.ack} !== 3'b000) begin
            errors++;
            $display("FAIL abort_strobes: got %b expected 000", {bus.mem_rd_en, bus.mem_wr_en, bus.ack});
        end
        exp_q.delete();
        bus.req = 1'b1;
        @(negedge clk);
        init_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (mem[80] !== model_out[16]) begin errors++; $display("FAIL abort_kept: got %h expected %h", mem[80], model_out[16]); end
        checks++;
        if (mem[81] !== 8'h01) begin errors++; $display("FAIL abort_no_write: got %h expected 01", mem[81]); end
        push_model(8'd12, 8'h48, 8'h35);
        run(lat);
        checks++;
        if (lat != 132) begin errors++; $display("FAIL relaunch_latency: got %0d expected 132", lat); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL relaunch_leftover: got %0d expected 0", exp_q.size()); exp_q.delete(); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (mem[64 + i] !== model_out[i]) begin
                errors++;
                $display("FAIL relaunch_byte[%0d]: got %h expected %h", i, mem[64 + i], model_out[i]);
            end
        end
    endtask

    task automatic test_req_toggle();
        int c0;
        int lat;
        load_dm(8'd20, 8'h6A, 8'h5B);
        push_model(8'd20, 8'h6A, 8'h5B);
        @(negedge clk);
        c0 = cyc;
        bus.req = 1'b0;
        for (int k = 0; k < 100 && cyc < c0 + 61; k++) @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.ack) begin lat = cyc - c0 - 1; break; end
        end
        checks++;
        if (lat != 132) begin errors++; $display("FAIL toggle_latency: got %0d expected 132", lat); end
        repeat (20) @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || dbg_state !== S_DONE) begin
            errors++;
            $display("FAIL ack_hold: got ack=%b state=%0d expected ack=1 state=%0d", bus.ack, dbg_state, S_DONE);
        end
        bus.req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL ack_release: got ack=%b state=%0d expected ack=0 state=%0d", bus.ack, dbg_state, S_IDLE);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL toggle_leftover: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: got no finish at time %0t, expected bench to complete", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        bus.req = 1'b0;
        test_reset();
        test_req_hold();
        test_basic();
        test_same_as_ref(8'd10, 8'h80);
        test_same_as_ref(8'd5, 8'h01);
        test_pre_max();
        test_patterns();
        test_abort();
        test_req_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
